// File: rtl/vjtag_dr_responder.sv
// Virtual JTAG user-side data-register engine.
// Decodes the 4-bit virtual IR, runs capture/shift/update on a 32-bit shift register,
// commits WRITE words to the fabric and returns IDCODE/READ/LOOP words.
// Optional feature macro: VJTAG_PARITY_EN (WRITE carries an even-parity bit above the data).
module vjtag_dr_responder #(
  parameter int unsigned DATA_W  = 8,
  parameter logic [31:0] USER_ID = 32'h5653_4A01
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [3:0]        ir_in,
  output logic [3:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid
);

  localparam logic [3:0] IrIdcode = 4'h1;
  localparam logic [3:0] IrWrite  = 4'h2;
  localparam logic [3:0] IrRead   = 4'h3;
  localparam logic [3:0] IrLoop   = 4'h4;
  localparam logic [3:0] IrClear  = 4'hF;

`ifdef VJTAG_PARITY_EN
  localparam int unsigned WrLen = DATA_W + 1;
`else
  localparam int unsigned WrLen = DATA_W;
`endif

  logic [31:0]       sr_q, sr_d, sr_shift, cap, keep_mask;
  logic [5:0]        cnt_q, cnt_d, len;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_valid_q, wr_seen_q, len_err_q, par_err;
  logic              wr_hit, len_ok, par_ok, commit, flag_clr;

  // Pause/exit/capture-IR states carry no action for this register.
  logic unused_states;
  assign unused_states = ^{virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr,
                           virtual_state_cir};

  // Instruction decode: scan length and capture value.
  always_comb begin
    len = 6'd1;
    cap = '0;
    case (ir_in)
      IrIdcode: begin
        len = 6'd32;
        cap = USER_ID;
      end
      IrWrite:  len = 6'(WrLen);
      IrRead: begin
        len = 6'(DATA_W);
        cap = 32'(rd_data);
      end
      IrLoop: begin
        len = 6'(DATA_W);
        cap = 32'(wr_data_q);
      end
      default: ;
    endcase
  end

  // Shift right within the active length; tdi enters at bit len-1, upper bits forced to 0.
  always_comb begin
    keep_mask = (len == 6'd32) ? '1 : ((32'd1 << len) - 32'd1);
    sr_shift  = ((sr_q >> 1) & (keep_mask >> 1)) | (32'(tdi) << (len - 6'd1));
  end

  // Capture/shift next state; capture wins if both states are asserted together.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (virtual_state_cdr) begin
      sr_d  = cap;
      cnt_d = '0;
    end else if (virtual_state_sdr) begin
      sr_d  = sr_shift;
      cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    end
  end

  // Update-DR decode for WRITE: commit only on exact length and good parity.
  always_comb begin
    wr_hit   = virtual_state_udr && (ir_in == IrWrite);
    len_ok   = (cnt_q == len);
`ifdef VJTAG_PARITY_EN
    par_ok   = (sr_q[DATA_W] == ^sr_q[DATA_W-1:0]);
`else
    par_ok   = 1'b1;
`endif
    commit   = wr_hit && len_ok && par_ok;
    flag_clr = virtual_state_uir && (ir_in == IrClear);
  end

  // Shift register, counter, write port and sticky status flags.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_seen_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      wr_valid_q <= commit;
      if (commit) wr_data_q <= sr_q[DATA_W-1:0];
      if (flag_clr) begin
        wr_seen_q <= 1'b0;
        len_err_q <= 1'b0;
      end else begin
        if (commit)             wr_seen_q <= 1'b1;
        if (wr_hit && !len_ok)  len_err_q <= 1'b1;
      end
    end
  end

`ifdef VJTAG_PARITY_EN
  logic par_err_q;

  // Sticky parity error on an exact-length WRITE whose parity bit disagrees.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)                               par_err_q <= 1'b0;
    else if (flag_clr)                        par_err_q <= 1'b0;
    else if (wr_hit && len_ok && !par_ok)     par_err_q <= 1'b1;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign tdo      = sr_q[0];
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign ir_out   = {par_err, 1'b0, len_err_q, wr_seen_q};

endmodule
